// File: rtl/interval_sched_pkg.sv
// interval_sched_pkg: shared types, default sizes and helpers for interval_sched
package interval_sched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NREQ_DEF = 4;
    localparam int CW_DEF = 5;
    // One-hot of index i; callers truncate to their width.
    function automatic logic [31:0] to_onehot(input int i);
        return 32'd1 << i;
    endfunction
endpackage

// File: rtl/interval_sched_if.sv
// interval_sched_if: request/grant bundle between clients and interval_sched
//   req/dur/abort driven by clients (master); gnt/done/busy/count by the scheduler (slave)
interface interval_sched_if #(
    parameter int NREQ = interval_sched_pkg::NREQ_DEF,
    parameter int CW = interval_sched_pkg::CW_DEF
);
    logic [NREQ-1:0] req;
    logic [NREQ*CW-1:0] dur;
    logic abort;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic busy;
    logic [CW-1:0] count;
    modport master (output req, dur, abort, input gnt, done, busy, count);
    modport slave (input req, dur, abort, output gnt, done, busy, count);
endinterface

// File: rtl/interval_sched_rr_pick.sv
// rr_pick: combinational round-robin picker
//   req: request vector; ptr: highest-priority index
//   valid: any request; idx: winner index; onehot: winner as one-hot (0 if none)
module rr_pick
    import interval_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic valid,
    output logic [IW-1:0] idx,
    output logic [NREQ-1:0] onehot
);
    // Scan from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        valid = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                valid = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end
    assign onehot = valid ? NREQ'(to_onehot(int'(idx))) : '0;
endmodule

// File: rtl/interval_sched.sv
// interval_sched: round-robin sharing of one interval counter among NREQ requesters
//   clk, rst (async, active-high)
//   bus.req/dur/abort in; bus.gnt (one-hot grant), bus.done (one-cycle pulse),
//   bus.busy (state != IDLE), bus.count (counter value) out
module interval_sched
    import interval_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW = CW_DEF
) (
    input logic clk,
    input logic rst,
    interval_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    state_t state, state_n;
    logic [IW-1:0] ptr, ptr_n, w, w_n, pick_idx;
    logic [CW-1:0] dur_q, dur_n, count, count_n, dur_sel;
    logic [NREQ-1:0] gnt, gnt_n, pick_oh;
    logic pick_valid;
    logic [IW-1:0] w_next;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req(bus.req),
        .ptr(ptr),
        .valid(pick_valid),
        .idx(pick_idx),
        .onehot(pick_oh)
    );

    assign dur_sel = bus.dur[int'(pick_idx)*CW +: CW];
    // After completion or abort the served requester drops to lowest priority.
    assign w_next = (int'(w) == NREQ - 1) ? '0 : w + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            w <= '0;
            dur_q <= '0;
            count <= '0;
            gnt <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            w <= w_n;
            dur_q <= dur_n;
            count <= count_n;
            gnt <= gnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n = ptr;
        w_n = w;
        dur_n = dur_q;
        count_n = count;
        gnt_n = gnt;
        case (state)
            IDLE: begin
                count_n = '0;
                if (!bus.abort && pick_valid) begin
                    w_n = pick_idx;
                    dur_n = dur_sel;
                    gnt_n = pick_oh;
                    state_n = (dur_sel != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    gnt_n = '0;
                    count_n = '0;
                    ptr_n = w_next;
                end else if (count == dur_q - 1'b1) begin
                    state_n = DONE;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n = '0;
                count_n = '0;
                ptr_n = w_next;
            end
        endcase
    end

    assign bus.gnt = gnt;
    assign bus.done = (state == DONE) ? gnt : '0;
    assign bus.busy = (state != IDLE);
    assign bus.count = count;
endmodule

// File: tb/tb_interval_sched.sv
// tb_interval_sched: directed self-checking bench for interval_sched
module tb_interval_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    interval_sched_if #(.NREQ(4), .CW(5)) bus ();

    interval_sched #(.NREQ(4), .CW(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_count"}, 32'(bus.count), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    initial begin
        bus.req = '0;
        bus.dur = '0;
        bus.abort = 1'b0;
        @(negedge clk);
        idle_chk("reset");
        @(negedge clk);
        rst = 1'b0;

        // single request, dur=3
        bus.req = 4'b0001;
        bus.dur[0 +: 5] = 5'd3;
        @(negedge clk);
        bus.req = '0;
        chk("single_gnt", 32'(bus.gnt), 32'b0001);
        chk("single_busy", 32'(bus.busy), 1);
        chk("single_c0", 32'(bus.count), 0);
        @(negedge clk);
        chk("single_c1", 32'(bus.count), 1);
        @(negedge clk);
        chk("single_c2", 32'(bus.count), 2);
        chk("single_nodone", 32'(bus.done), 0);
        @(negedge clk);
        chk("single_done", 32'(bus.done), 32'b0001);
        chk("single_gnt4", 32'(bus.gnt), 32'b0001);
        chk("single_hold", 32'(bus.count), 2);
        @(negedge clk);
        idle_chk("single_end");

        // zero duration
        bus.req = 4'b0100;
        bus.dur[10 +: 5] = 5'd0;
        @(negedge clk);
        bus.req = '0;
        chk("zero_gnt", 32'(bus.gnt), 32'b0100);
        chk("zero_done", 32'(bus.done), 32'b0100);
        chk("zero_busy", 32'(bus.busy), 1);
        @(negedge clk);
        idle_chk("zero_end");

        // round robin from ptr=0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1111;
        bus.dur = {4{5'd1}};
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(bus.gnt), 32'd1 << (g % 4));
            chk("rr_run_nodone", 32'(bus.done), 0);
            @(negedge clk);
            chk("rr_done", 32'(bus.done), 32'd1 << (g % 4));
            @(negedge clk);
            if (g == 4) bus.req = '0;
            chk("rr_idle_gnt", 32'(bus.gnt), 0);
            chk("rr_idle_busy", 32'(bus.busy), 0);
        end

        // abort: ptr=1 now, requester 1 wins
        bus.req = 4'b0110;
        bus.dur[5 +: 5] = 5'd10;
        bus.dur[10 +: 5] = 5'd2;
        @(negedge clk);
        chk("abort_gnt1", 32'(bus.gnt), 32'b0010);
        @(negedge clk);
        @(negedge clk);
        chk("abort_c2", 32'(bus.count), 2);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        idle_chk("abort_idle");
        @(negedge clk);
        bus.req = '0;
        chk("abort_next_gnt", 32'(bus.gnt), 32'b0100);
        @(negedge clk);
        chk("abort_next_c1", 32'(bus.count), 1);
        @(negedge clk);
        chk("abort_next_done", 32'(bus.done), 32'b0100);
        @(negedge clk);
        idle_chk("abort_next_end");

        // abort in IDLE blocks the grant
        bus.req = 4'b0001;
        bus.abort = 1'b1;
        bus.dur[0 +: 5] = 5'd31;
        @(negedge clk);
        bus.abort = 1'b0;
        idle_chk("idle_abort");

        // max duration
        @(negedge clk);
        bus.req = '0;
        chk("max_gnt", 32'(bus.gnt), 32'b0001);
        chk("max_c0", 32'(bus.count), 0);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            chk("max_count", 32'(bus.count), 32'(i));
            chk("max_nodone", 32'(bus.done), 0);
        end
        @(negedge clk);
        chk("max_done", 32'(bus.done), 32'b0001);
        chk("max_hold", 32'(bus.count), 30);
        @(negedge clk);
        idle_chk("max_end");

        // async reset mid-RUN
        bus.req = 4'b0001;
        bus.dur[0 +: 5] = 5'd10;
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("arst_c3", 32'(bus.count), 3);
        #1 rst = 1'b1;
        #1 idle_chk("arst");
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1001;
        @(negedge clk);
        bus.req = '0;
        chk("arst_ptr0", 32'(bus.gnt), 32'b0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1000;
        @(negedge clk);
        chk("arst_gnt3", 32'(bus.gnt), 32'b1000);
        bus.req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/interval_sched.md
Name: interval_sched

Overview:
Round-robin scheduler that shares one CW-bit up-counting interval timer among NREQ requesters. Each requester presents a duration. The scheduler grants one requester at a time, runs the shared counter for exactly that many cycles, then pulses that requester's done bit. It sits between client control FSMs and the shared counter datapath.

Parameters:
NREQ, 4, number of requesters (>=2)
CW, 5, counter/duration width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level
dur  input  NREQ*CW  flattened durations; requester i at bits [i*CW +: CW]
abort  input  1  cancels the interval in progress
gnt  output  NREQ  one-hot grant, zero when idle
done  output  NREQ  one-hot completion pulse, one cycle
busy  output  1  high whenever state != IDLE
count  output  CW  current counter value

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, done=0, busy=0, count=0, rr pointer ptr=0, latched winner w=0, latched duration dur_q=0.
- States: IDLE, RUN, DONE. Everything except done is registered. done = gnt when state==DONE, else 0.
- Winner selection in IDLE: the first set bit of req, searching ptr, ptr+1, ... mod NREQ.
- IDLE, abort=1: no grant this cycle; stay IDLE.
- IDLE, req!=0, abort=0, at the edge:
  - latch w and dur_q=dur[w]; set gnt=onehot(w); set count=0.
  - If dur[w]!=0, go to RUN. If dur[w]==0, go directly to DONE.
- IDLE, req==0: hold; count=0.
- RUN, at the edge:
  - abort=1: go to IDLE; gnt=0; count=0; ptr=(w+1) mod NREQ; no done pulse.
  - Otherwise, count==dur_q-1: go to DONE; count holds its value.
  - Otherwise: count=count+1.
- RUN length: exactly dur_q cycles; count shows 0..dur_q-1. No overflow is possible, since the maximum count is 2^CW-2.
- DONE: lasts one cycle with gnt and done asserted. At the edge: go to IDLE; gnt=0; count=0; ptr=(w+1) mod NREQ. abort is ignored in DONE.
- Latency: req sampled at edge k gives gnt from edge k. done is asserted in cycle k+dur, then at least one IDLE cycle follows.
- Per-grant cost: dur+2 cycles, or 2 cycles when dur=0.
- req or dur changing while granted: ignored; the latched values are used.
- req dropping while granted: the interval still completes.
- Fairness: after any completion or abort, the served requester becomes lowest priority.

Decomposition:
- Shared package interval_sched_pkg holds:
  - state typedef enum {IDLE, RUN, DONE}
  - default constants NREQ_DEF=4, CW_DEF=5
  - onehot helper function
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: valid, idx, onehot.
- The counter is implemented inline in interval_sched.

Test Plan:
- Single request: req=0001, dur0=3 at cycle 0 -> gnt=0001 cycles 1-4; count 0,1,2 in cycles 1-3; done=0001 in cycle 4 only; busy low and gnt=0 at cycle 5.
- Round robin: req=1111, all dur=1, held -> grant order 0,1,2,3,0. Each grant gives RUN (1 cycle), DONE (1 cycle), IDLE (1 cycle). done pulses every 3 cycles.
- Zero duration: req=0100, dur2=0 -> gnt=0100 and done=0100 in the same single cycle; no RUN; busy high for 1 cycle.
- Abort: req=0110, dur1=10, abort pulsed when count=2 -> next cycle gnt=0, count=0, no done[1]; following grant goes to requester 2.
- Max duration: dur0=31 -> RUN for 31 cycles; count reaches 30 and holds 30 during DONE; done[0] pulses once; no wrap.
- Async reset mid-RUN: rst asserted between edges while count=3 -> gnt, done, busy and count become 0 immediately. After release, req=1000 gives requester 3 the grant, with ptr reset to 0.
